// File: rtl/reaction_round_ctrl.sv
// reaction_round_ctrl
// Round sequencer and two-player buzzer arbiter for the reaction game.
// Each raw button is synchronised and debounced. A press is a rising edge of the
// debounced level. Every sym_new opens a response window. The first press inside
// the window decides the round, and one-cycle score pulses are emitted per player.
//
// Ports
//   clk        in   system clock
//   clr        in   synchronous active-high reset
//   btn_p1     in   raw player-1 button (asynchronous, bouncy)
//   btn_p2     in   raw player-2 button (asynchronous, bouncy)
//   sym_new    in   1-cycle pulse: a new symbol is now displayed
//   symbol     in   [1:0] currently displayed symbol, sampled on sym_new
//   p1_inc     out  1-cycle pulse: player 1 score +1
//   p1_dec     out  1-cycle pulse: player 1 score -1
//   p2_inc     out  1-cycle pulse: player 2 score +1
//   p2_dec     out  1-cycle pulse: player 2 score -1
//   winner     out  [1:0] last round result: 0 none/timeout, 1 p1, 2 p2, 3 tie
//   round_open out  high while presses are accepted
module reaction_round_ctrl #(
  parameter int unsigned DB_CYCLES     = 16,
  parameter int unsigned WINDOW_CYCLES = 100000000,
  parameter logic [1:0]  TARGET        = 2'd3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_p1,
  input  logic       btn_p2,
  input  logic       sym_new,
  input  logic [1:0] symbol,
  output logic       p1_inc,
  output logic       p1_dec,
  output logic       p2_inc,
  output logic       p2_dec,
  output logic [1:0] winner,
  output logic       round_open
);

  localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam int unsigned DB_W  = $clog2(DB_CYCLES + 1);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    RESULT = 2'd2,
    LOCK   = 2'd3
  } state_t;

  // Bit 0 is player 1 and bit 1 is player 2 throughout the input path.
  logic [1:0]            raw;
  logic [1:0]            sync_a;
  logic [1:0]            sync_b;
  logic [1:0]            db;
  logic [1:0]            db_q;
  logic [1:0][DB_W-1:0]  db_cnt;
  logic [1:0]            press;

  state_t                state;
  logic [WIN_W-1:0]      win_cnt;
  logic                  sym_tgt;

  assign raw   = {btn_p2, btn_p1};
  assign press = db & ~db_q;

  // Two-flop synchroniser and debounce counter per button.
  // The debounced level flips only after DB_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync_a <= '0;
      sync_b <= '0;
      db     <= '0;
      db_q   <= '0;
      db_cnt <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      db_q   <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Round FSM. Pulses are computed on the OPEN->RESULT transition with the
  // sym_tgt value that was current before any same-cycle sym_new. The pulses
  // are therefore visible during RESULT and are judged against the old symbol.
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      win_cnt    <= '0;
      sym_tgt    <= 1'b0;
      winner     <= 2'd0;
      round_open <= 1'b0;
      p1_inc     <= 1'b0;
      p1_dec     <= 1'b0;
      p2_inc     <= 1'b0;
      p2_dec     <= 1'b0;
    end else begin
      p1_inc <= 1'b0;
      p1_dec <= 1'b0;
      p2_inc <= 1'b0;
      p2_dec <= 1'b0;

      if (sym_new) begin
        sym_tgt <= (symbol == TARGET);
      end

      case (state)
        IDLE, LOCK: begin
          if (sym_new) begin
            state      <= OPEN;
            win_cnt    <= WIN_LOAD;
            round_open <= 1'b1;
          end
        end

        OPEN: begin
          if (|press) begin
            state      <= RESULT;
            round_open <= 1'b0;
            // The press vector {p2,p1} is already the winner code (01, 10, 11=tie).
            winner     <= press;
            if (sym_tgt) begin
              p1_inc <= (press == 2'b01);
              p2_inc <= (press == 2'b10);
            end else begin
              p1_dec <= press[0];
              p2_dec <= press[1];
            end
          end else if (sym_new) begin
            win_cnt <= WIN_LOAD;
          end else if (win_cnt == '0) begin
            state      <= LOCK;
            round_open <= 1'b0;
            winner     <= 2'd0;
          end else begin
            win_cnt <= win_cnt - WIN_W'(1);
          end
        end

        RESULT: begin
          if (sym_new) begin
            state      <= OPEN;
            win_cnt    <= WIN_LOAD;
            round_open <= 1'b1;
          end else begin
            state <= LOCK;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed testbench for reaction_round_ctrl (DB_CYCLES=4, WINDOW_CYCLES=20).
module tb_reaction_round_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       btn_p1;
  logic       btn_p2;
  logic       sym_new;
  logic [1:0] symbol;
  logic       p1_inc;
  logic       p1_dec;
  logic       p2_inc;
  logic       p2_dec;
  logic [1:0] winner;
  logic       round_open;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Pulse tallies sampled on the falling edge.
  int n_p1i = 0, n_p1d = 0, n_p2i = 0, n_p2d = 0, excl_viol = 0;
  int s_p1i, s_p1d, s_p2i, s_p2d;

  reaction_round_ctrl #(
    .DB_CYCLES    (4),
    .WINDOW_CYCLES(20),
    .TARGET       (2'd3)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .btn_p1    (btn_p1),
    .btn_p2    (btn_p2),
    .sym_new   (sym_new),
    .symbol    (symbol),
    .p1_inc    (p1_inc),
    .p1_dec    (p1_dec),
    .p2_inc    (p2_inc),
    .p2_dec    (p2_dec),
    .winner    (winner),
    .round_open(round_open)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (p1_inc) n_p1i++;
    if (p1_dec) n_p1d++;
    if (p2_inc) n_p2i++;
    if (p2_dec) n_p2d++;
    if ((p1_inc && p1_dec) || (p2_inc && p2_dec)) excl_viol++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic take_snap();
    s_p1i = n_p1i; s_p1d = n_p1d; s_p2i = n_p2i; s_p2d = n_p2d;
  endtask

  task automatic open_round(input logic [1:0] sym);
    sym_new = 1'b1;
    symbol  = sym;
    step();
    sym_new = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; btn_p1 = 1'b0; btn_p2 = 1'b0; sym_new = 1'b0; symbol = 2'd0;
    steps(3);
    total_cnt++;
    if ({p1_inc, p1_dec, p2_inc, p2_dec} !== 4'b0000)
      $display("FAIL reset_pulses got %b want 0000", {p1_inc, p1_dec, p2_inc, p2_dec});
    else pass_cnt++;
    total_cnt++;
    if (winner !== 2'd0) $display("FAIL reset_winner got %0d want 0", winner);
    else pass_cnt++;
    total_cnt++;
    if (round_open !== 1'b0) $display("FAIL reset_round_open got %b want 0", round_open);
    else pass_cnt++;
    clr = 1'b0;
    steps(2);
  endtask

  task automatic test_glitch();
    int n;
    take_snap();
    open_round(2'd3);
    total_cnt++;
    if (round_open !== 1'b1) $display("FAIL glitch_open got %b want 1", round_open);
    else pass_cnt++;
    btn_p1 = 1'b1; step(); btn_p1 = 1'b0; step();
    btn_p1 = 1'b1; step(); btn_p1 = 1'b0;
    steps(8);
    total_cnt++;
    if ((n_p1i - s_p1i) !== 0 || (n_p1d - s_p1d) !== 0 || (n_p2i - s_p2i) !== 0 || (n_p2d - s_p2d) !== 0)
      $display("FAIL glitch_pulses got p1i=%0d p1d=%0d p2i=%0d p2d=%0d want all 0",
               n_p1i - s_p1i, n_p1d - s_p1d, n_p2i - s_p2i, n_p2d - s_p2d);
    else pass_cnt++;
    total_cnt++;
    if (round_open !== 1'b1 || winner !== 2'd0)
      $display("FAIL glitch_state got open=%b winner=%0d want open=1 winner=0", round_open, winner);
    else pass_cnt++;
    n = 0;
    while (round_open === 1'b1 && n < 30) begin step(); n++; end
    total_cnt++;
    if (round_open !== 1'b0) $display("FAIL glitch_close got open=%b want 0 within 30 cycles", round_open);
    else pass_cnt++;
    steps(2);
  endtask

  task automatic test_p1_inc();
    int n;
    bit seen;
    take_snap();
    open_round(2'd3);
    step();
    btn_p1 = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 30) begin
      step(); n++;
      if (p1_inc === 1'b1) seen = 1;
    end
    total_cnt++;
    if (!seen || n !== 7) $display("FAIL p1_inc_latency got seen=%0d cycles=%0d want seen=1 cycles=7", seen, n);
    else pass_cnt++;
    steps(4);
    total_cnt++;
    if ((n_p1i - s_p1i) !== 1 || (n_p1d - s_p1d) !== 0 || (n_p2i - s_p2i) !== 0 || (n_p2d - s_p2d) !== 0)
      $display("FAIL p1_inc_count got p1i=%0d p1d=%0d p2i=%0d p2d=%0d want 1 0 0 0",
               n_p1i - s_p1i, n_p1d - s_p1d, n_p2i - s_p2i, n_p2d - s_p2d);
    else pass_cnt++;
    total_cnt++;
    if (winner !== 2'd1 || round_open !== 1'b0)
      $display("FAIL p1_inc_state got winner=%0d open=%b want winner=1 open=0", winner, round_open);
    else pass_cnt++;
    btn_p1 = 1'b0;
    steps(8);
  endtask

  task automatic test_p2_dec();
    int n;
    take_snap();
    open_round(2'd1);
    btn_p2 = 1'b1;
    n = 0;
    while (p2_dec !== 1'b1 && n < 30) begin step(); n++; end
    steps(4);
    total_cnt++;
    if ((n_p1i - s_p1i) !== 0 || (n_p1d - s_p1d) !== 0 || (n_p2i - s_p2i) !== 0 || (n_p2d - s_p2d) !== 1)
      $display("FAIL p2_dec_count got p1i=%0d p1d=%0d p2i=%0d p2d=%0d want 0 0 0 1",
               n_p1i - s_p1i, n_p1d - s_p1d, n_p2i - s_p2i, n_p2d - s_p2d);
    else pass_cnt++;
    total_cnt++;
    if (winner !== 2'd2) $display("FAIL p2_dec_winner got %0d want 2", winner);
    else pass_cnt++;
    btn_p2 = 1'b0;
    steps(8);
  endtask

  task automatic test_tie();
    int n;
    take_snap();
    open_round(2'd3);
    btn_p1 = 1'b1; btn_p2 = 1'b1;
    steps(12);
    total_cnt++;
    if ((n_p1i - s_p1i) !== 0 || (n_p1d - s_p1d) !== 0 || (n_p2i - s_p2i) !== 0 || (n_p2d - s_p2d) !== 0)
      $display("FAIL tie_target_pulses got p1i=%0d p1d=%0d p2i=%0d p2d=%0d want all 0",
               n_p1i - s_p1i, n_p1d - s_p1d, n_p2i - s_p2i, n_p2d - s_p2d);
    else pass_cnt++;
    total_cnt++;
    if (winner !== 2'd3 || round_open !== 1'b0)
      $display("FAIL tie_target_state got winner=%0d open=%b want winner=3 open=0", winner, round_open);
    else pass_cnt++;
    btn_p1 = 1'b0; btn_p2 = 1'b0;
    steps(8);

    take_snap();
    open_round(2'd0);
    btn_p1 = 1'b1; btn_p2 = 1'b1;
    n = 0;
    while (p1_dec !== 1'b1 && p2_dec !== 1'b1 && n < 30) begin step(); n++; end
    total_cnt++;
    if ({p1_dec, p2_dec} !== 2'b11) $display("FAIL tie_both_dec got p1d,p2d=%b want 11", {p1_dec, p2_dec});
    else pass_cnt++;
    steps(4);
    total_cnt++;
    if ((n_p1i - s_p1i) !== 0 || (n_p1d - s_p1d) !== 1 || (n_p2i - s_p2i) !== 0 || (n_p2d - s_p2d) !== 1 || winner !== 2'd3)
      $display("FAIL tie_dec_count got p1i=%0d p1d=%0d p2i=%0d p2d=%0d winner=%0d want 0 1 0 1 winner=3",
               n_p1i - s_p1i, n_p1d - s_p1d, n_p2i - s_p2i, n_p2d - s_p2d, winner);
    else pass_cnt++;
    btn_p1 = 1'b0; btn_p2 = 1'b0;
    steps(8);
  endtask

  task automatic test_timeout();
    int n;
    take_snap();
    open_round(2'd3);
    n = 0;
    while (round_open === 1'b1 && n < 40) begin step(); n++; end
    total_cnt++;
    if (n !== 20) $display("FAIL timeout_length got %0d cycles want 20", n);
    else pass_cnt++;
    total_cnt++;
    if (winner !== 2'd0) $display("FAIL timeout_winner got %0d want 0", winner);
    else pass_cnt++;
    btn_p1 = 1'b1;
    steps(12);
    total_cnt++;
    if ((n_p1i - s_p1i) !== 0 || (n_p1d - s_p1d) !== 0 || (n_p2i - s_p2i) !== 0 || (n_p2d - s_p2d) !== 0 ||
        round_open !== 1'b0 || winner !== 2'd0)
      $display("FAIL lock_press got p1i=%0d p1d=%0d p2i=%0d p2d=%0d open=%b winner=%0d want 0 0 0 0 open=0 winner=0",
               n_p1i - s_p1i, n_p1d - s_p1d, n_p2i - s_p2i, n_p2d - s_p2d, round_open, winner);
    else pass_cnt++;
    btn_p1 = 1'b0;
    steps(8);
  endtask

  task automatic test_press_with_sym_new();
    take_snap();
    btn_p1 = 1'b1;
    step();                  // raw sampled by first synchroniser flop
    open_round(2'd3);        // target symbol round opens
    steps(4);                // debounced level rises at the end of this run
    sym_new = 1'b1;
    symbol  = 2'd0;
    step();                  // press and sym_new sampled on the same edge
    total_cnt++;
    if (p1_inc !== 1'b1 || p1_dec !== 1'b0)
      $display("FAIL coincident_judge got p1_inc=%b p1_dec=%b want 1 0", p1_inc, p1_dec);
    else pass_cnt++;
    total_cnt++;
    if (winner !== 2'd1) $display("FAIL coincident_winner got %0d want 1", winner);
    else pass_cnt++;
    sym_new = 1'b0;
    step();
    total_cnt++;
    if (round_open !== 1'b0) $display("FAIL coincident_dropped got open=%b want 0", round_open);
    else pass_cnt++;
    steps(3);
    total_cnt++;
    if ((n_p1i - s_p1i) !== 1 || (n_p1d - s_p1d) !== 0 || (n_p2i - s_p2i) !== 0 || (n_p2d - s_p2d) !== 0)
      $display("FAIL coincident_count got p1i=%0d p1d=%0d p2i=%0d p2d=%0d want 1 0 0 0",
               n_p1i - s_p1i, n_p1d - s_p1d, n_p2i - s_p2i, n_p2d - s_p2d);
    else pass_cnt++;
    btn_p1 = 1'b0;
    steps(8);
  endtask

  task automatic test_back_to_back();
    int n;
    take_snap();
    open_round(2'd3);
    btn_p1 = 1'b1;
    n = 0;
    while (p1_inc !== 1'b1 && n < 30) begin step(); n++; end
    sym_new = 1'b1;          // arrives during RESULT
    symbol  = 2'd0;
    step();
    sym_new = 1'b0;
    total_cnt++;
    if (round_open !== 1'b1) $display("FAIL b2b_reopen got open=%b want 1", round_open);
    else pass_cnt++;
    btn_p1 = 1'b0;
    btn_p2 = 1'b1;
    n = 0;
    while (p2_dec !== 1'b1 && p2_inc !== 1'b1 && p1_inc !== 1'b1 && p1_dec !== 1'b1 && n < 30) begin
      step(); n++;
    end
    total_cnt++;
    if ({p1_inc, p1_dec, p2_inc, p2_dec} !== 4'b0001)
      $display("FAIL b2b_second_round got p1i,p1d,p2i,p2d=%b want 0001", {p1_inc, p1_dec, p2_inc, p2_dec});
    else pass_cnt++;
    steps(4);
    total_cnt++;
    if ((n_p1i - s_p1i) !== 1 || (n_p1d - s_p1d) !== 0 || (n_p2i - s_p2i) !== 0 || (n_p2d - s_p2d) !== 1 || winner !== 2'd2)
      $display("FAIL b2b_count got p1i=%0d p1d=%0d p2i=%0d p2d=%0d winner=%0d want 1 0 0 1 winner=2",
               n_p1i - s_p1i, n_p1d - s_p1d, n_p2i - s_p2i, n_p2d - s_p2d, winner);
    else pass_cnt++;
    btn_p2 = 1'b0;
    steps(8);
  endtask

  task automatic test_clr_mid();
    take_snap();
    open_round(2'd3);
    btn_p2 = 1'b1;
    steps(3);
    clr = 1'b1;
    step();
    total_cnt++;
    if (round_open !== 1'b0 || winner !== 2'd0)
      $display("FAIL clr_mid_state got open=%b winner=%0d want open=0 winner=0", round_open, winner);
    else pass_cnt++;
    clr = 1'b0;
    steps(12);
    total_cnt++;
    if ((n_p1i - s_p1i) !== 0 || (n_p1d - s_p1d) !== 0 || (n_p2i - s_p2i) !== 0 || (n_p2d - s_p2d) !== 0 ||
        round_open !== 1'b0)
      $display("FAIL clr_mid_pulses got p1i=%0d p1d=%0d p2i=%0d p2d=%0d open=%b want 0 0 0 0 open=0",
               n_p1i - s_p1i, n_p1d - s_p1d, n_p2i - s_p2i, n_p2d - s_p2d, round_open);
    else pass_cnt++;
    btn_p2 = 1'b0;
    steps(8);
  endtask

  initial begin
    clr = 1'b1; btn_p1 = 1'b0; btn_p2 = 1'b0; sym_new = 1'b0; symbol = 2'd0;
    test_reset();
    test_glitch();
    test_p1_inc();
    test_p2_dec();
    test_tie();
    test_timeout();
    test_press_with_sym_new();
    test_back_to_back();
    test_clr_mid();
    total_cnt++;
    if (excl_viol !== 0) $display("FAIL inc_dec_exclusive got %0d overlapping cycles want 0", excl_viol);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
